uart_rx_deserializer: RTL

//  UART receive stage directly downstream of the baud generator. Detects a start bit on the serial line and fires the generator's trigger.

---
 rtl/uart_rx_deserializer_if.sv | 47 ++++
 rtl/uart_rx_deserializer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if: baud-generator handshake and CPU-side receive
// register signals of the UART receive deserializer.
// The master modport is the deserializer. The slave modport is its
// environment: the baud generator plus the peripheral bus.
interface uart_rx_deserializer_if #(
    parameter int DATA_BITS = 8
) ();
    // Baud generator side
    logic                 baud_tick;     // mid start bit, then mid each data bit
    logic                 baud_status;   // generator busy level
    logic                 baud_finish;   // end of frame, after the stop bit
    logic                 baud_trigger;  // one-cycle start request
    logic                 baud_enable;   // receiver idle, generator may be started

    // CPU peripheral bus side
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_read;
    logic                 rx_overrun;
    logic                 rx_frame_err;

    modport master (
        input  baud_tick,
        input  baud_status,
        input  baud_finish,
        input  rx_read,
        output baud_trigger,
        output baud_enable,
        output rx_data,
        output rx_valid,
        output rx_overrun,
        output rx_frame_err
    );

    modport slave (
        output baud_tick,
        output baud_status,
        output baud_finish,
        output rx_read,
        input  baud_trigger,
        input  baud_enable,
        input  rx_data,
        input  rx_valid,
        input  rx_overrun,
        input  rx_frame_err
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART receive stage sitting directly behind the baud
// generator. It detects a start bit on the synchronised serial line, fires
// the generator trigger, shifts in DATA_BITS bits (LSB first) on the mid-bit
// ticks, and delivers the byte when the generator reports end of frame.
//
// Optional feature macro: UART_RX_FRAME_CHECK_EN
//   defined     - a frame whose stop bit leaves the line low is discarded and
//                 the sticky rx_frame_err flag is raised.
//   not defined - rx_frame_err is tied low; every completed frame is delivered.
//
// Receive handshake (rx_valid / rx_read): rx_valid high means rx_data holds
// an unread byte. A cycle with rx_read high pops it (rx_valid falls next
// cycle) and also clears the sticky rx_overrun / rx_frame_err flags, whether
// or not a byte was present. A new byte arriving while rx_valid is high and
// rx_read is low sets rx_overrun. A delivery in the same cycle as rx_read
// wins: rx_valid stays high and no overrun is recorded.
module uart_rx_deserializer #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   uart_rx,
    uart_rx_deserializer_if.master bus,
    output logic [2:0]             dbg_state_o
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t                 state_q,   state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   armed_q,   armed_d;
    logic                   trig_q,    trig_d;
    logic [1:0]             arm_cnt_q, arm_cnt_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q,   shift_d;
    logic                   deliver;

    logic [DATA_BITS-1:0]   data_q,    data_d;
    logic                   valid_q,   valid_d;
    logic                   ovr_q,     ovr_d;

`ifdef UART_RX_FRAME_CHECK_EN
    logic                   frame_bad;
    logic                   ferr_q,    ferr_d;
`endif

    // Line synchroniser: resets to the idle (high) level so no false start
    // bit is seen while the chain refills after reset.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Frame-tracking state register: FSM, arm flag, trigger, counters, shifter.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            trig_q    <= 1'b0;
            arm_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            trig_q    <= trig_d;
            arm_cnt_q <= arm_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Frame FSM next state: start detection, generator handshake, bit capture.
    always_comb begin
        state_d   = state_q;
        trig_d    = 1'b0;
        arm_cnt_d = arm_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        deliver   = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
        frame_bad = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                arm_cnt_d = '0;
                // Level test, so a start bit overlapping baud_finish is caught.
                if (!rx_s && armed_q && !bus.baud_status) begin
                    trig_d  = 1'b1;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                // Give the generator four cycles to report busy, else give up.
                if (bus.baud_status) begin
                    arm_cnt_d = '0;
                    state_d   = S_START;
                end else if (arm_cnt_q == 2'd3) begin
                    arm_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    arm_cnt_d = arm_cnt_q + 2'd1;
                end
            end
            S_START: begin
                if (bus.baud_tick) begin
                    if (!rx_s) begin
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                    end else begin
                        // Line came back high by mid start bit: a glitch.
                        // The generator still runs its frame, so wait it out.
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DATA: begin
                if (bus.baud_tick) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (bus.baud_finish) begin
                    state_d = S_IDLE;
`ifdef UART_RX_FRAME_CHECK_EN
                    if (!armed_q) begin
                        frame_bad = 1'b1;
                    end else begin
                        deliver = 1'b1;
                    end
`else
                    deliver = 1'b1;
`endif
                end
            end
            S_DRAIN: begin
                if (bus.baud_finish) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Arm flag: proves the line was seen high before a new start bit is taken.
    always_comb begin
        armed_d = armed_q;
        if (trig_d) begin
            armed_d = 1'b0;
        end else if (rx_s) begin
            armed_d = 1'b1;
`ifdef UART_RX_FRAME_CHECK_EN
        end else if (state_q == S_STOP) begin
            // While waiting for end of frame the flag follows the line, so a
            // stop bit that leaves the line low shows up as armed==0 at
            // baud_finish (and blocks a re-trigger until the line rises).
            armed_d = 1'b0;
`endif
        end
    end

    // Receive register next state: pop, delivery and sticky error flags.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
`ifdef UART_RX_FRAME_CHECK_EN
        ferr_d  = ferr_q;
`endif
        if (bus.rx_read) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
            ferr_d  = 1'b0;
`endif
        end
        if (deliver) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !bus.rx_read) begin
                ovr_d = 1'b1;
            end
        end
`ifdef UART_RX_FRAME_CHECK_EN
        if (frame_bad) begin
            ferr_d = 1'b1;
        end
`endif
    end

    // Receive register: byte and flags seen by the CPU.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef UART_RX_FRAME_CHECK_EN
    // Sticky frame-error flag, cleared only by reset or rx_read.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
        end
    end

    assign bus.rx_frame_err = ferr_q;
`else
    assign bus.rx_frame_err = 1'b0;
`endif

    assign bus.baud_trigger = trig_q;
    assign bus.baud_enable  = (state_q == S_IDLE);
    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_overrun   = ovr_q;
    assign dbg_state_o      = state_q;

endmodule
